// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit, one shift step per clock.
// Define MULDIV_RESULT_CACHE_EN to add a one-entry cache of the last completed division.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0]       OP_MUL    = 3'b000;
    localparam logic [2:0]       OP_MULH   = 3'b001;
    localparam logic [2:0]       OP_MULHSU = 3'b010;
    localparam logic [2:0]       OP_DIV    = 3'b100;
    localparam logic [2:0]       OP_REM    = 3'b110;
    localparam logic [XLEN-1:0]  ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES      = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t             state_r, state_s;
    logic [2:0]         op_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*XLEN-1:0]  acc_r;
    logic [XLEN-1:0]    opnd_r;
    logic               neg_r, rem_neg_r;
    logic [XLEN-1:0]    result_r, result_s;
    logic               load_s, step_s, result_we_s, cache_we_s;

    // Operand decode for the IDLE accept cycle
    logic            a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s;
    logic            div_zero_s, div_ovf_s, special_s;
    logic [XLEN-1:0] special_res_s;
    logic            cache_hit_s;
    logic [XLEN-1:0] cache_res_s;

    assign a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg_s    = a_signed_s & operand1[XLEN-1];
    assign b_neg_s    = b_signed_s & operand2[XLEN-1];
    assign a_mag_s    = neg_if(operand1, a_neg_s);
    assign b_mag_s    = neg_if(operand2, b_neg_s);
    assign div_zero_s = op[2] && (operand2 == ZERO);
    assign div_ovf_s  = op[2] && !op[0] && (operand1 == MIN_NEG) && (operand2 == ONES);
    assign special_s  = div_zero_s || div_ovf_s;

    // Results that bypass iteration: divide by zero and signed overflow
    always_comb begin
        special_res_s = ZERO;
        if (div_zero_s) begin
            special_res_s = op[1] ? operand1 : ONES;
        end else begin
            special_res_s = op[1] ? ZERO : operand1;
        end
    end

    // Multiply: acc holds {partial high, remaining multiplier bits}
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_step_s, mul_full_s;
    assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    assign mul_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    assign mul_full_s = neg_wide_if(mul_step_s, neg_r);

    // Divide: acc holds {partial remainder, dividend shifting into quotient}
    logic [XLEN:0]     div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] div_step_s;
    logic [XLEN-1:0]   div_quo_s, div_rem_s;
    assign div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_step_s  = div_diff_s[XLEN] ? {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                                          : {div_diff_s[XLEN-1:0],  acc_r[XLEN-2:0], 1'b1};
    assign div_quo_s   = neg_if(div_step_s[XLEN-1:0], neg_r);
    assign div_rem_s   = neg_if(div_step_s[2*XLEN-1:XLEN], rem_neg_r);

    // Next-state and datapath control
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        result_we_s = 1'b0;
        result_s    = result_r;
        cache_we_s  = 1'b0;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!start) begin
                        state_s = ST_IDLE;
                    end else if (special_s) begin
                        result_s    = special_res_s;
                        result_we_s = 1'b1;
                        state_s     = ST_DONE;
                    end else if (cache_hit_s) begin
                        result_s    = cache_res_s;
                        result_we_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        load_s  = 1'b1;
                        state_s = op[2] ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    step_s = 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        result_s    = (op_r == OP_MUL) ? mul_full_s[XLEN-1:0] : mul_full_s[2*XLEN-1:XLEN];
                        result_we_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        state_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    step_s = 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        result_s    = op_r[1] ? div_rem_s : div_quo_s;
                        result_we_s = 1'b1;
                        cache_we_s  = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        state_s = ST_DIV;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r      <= 3'b000;
            cnt_r     <= CNT_ZERO;
            acc_r     <= {(2*XLEN){1'b0}};
            opnd_r    <= ZERO;
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            result_r  <= ZERO;
        end else begin
            if (load_s) begin
                op_r      <= op;
                cnt_r     <= CNT_ZERO;
                acc_r     <= op[2] ? {ZERO, a_mag_s} : {ZERO, b_mag_s};
                opnd_r    <= op[2] ? b_mag_s : a_mag_s;
                neg_r     <= a_neg_s ^ b_neg_s;
                rem_neg_r <= a_neg_s;
            end else if (step_s) begin
                acc_r <= (state_r == ST_MUL) ? mul_step_s : div_step_s;
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (result_we_s) begin
                result_r <= result_s;
            end
        end
    end

`ifdef MULDIV_RESULT_CACHE_EN
    logic [XLEN-1:0] orig_a_r, orig_b_r;
    logic            cache_valid_r, cache_signed_r;
    logic [XLEN-1:0] cache_a_r, cache_b_r, cache_q_r, cache_rem_r;

    assign cache_hit_s = cache_valid_r && op[2] && (operand1 == cache_a_r) &&
                         (operand2 == cache_b_r) && (cache_signed_r == ~op[0]);
    assign cache_res_s = op[1] ? cache_rem_r : cache_q_r;

    // Raw operands are kept because the inputs may change while iterating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            orig_a_r       <= ZERO;
            orig_b_r       <= ZERO;
            cache_valid_r  <= 1'b0;
            cache_signed_r <= 1'b0;
            cache_a_r      <= ZERO;
            cache_b_r      <= ZERO;
            cache_q_r      <= ZERO;
            cache_rem_r    <= ZERO;
        end else begin
            if (load_s) begin
                orig_a_r <= operand1;
                orig_b_r <= operand2;
            end
            if (cache_we_s) begin
                cache_valid_r  <= 1'b1;
                cache_signed_r <= ~op_r[0];
                cache_a_r      <= orig_a_r;
                cache_b_r      <= orig_b_r;
                cache_q_r      <= div_quo_s;
                cache_rem_r    <= div_rem_s;
            end
        end
    end
`else
    logic cache_we_unused_s;
    assign cache_hit_s       = 1'b0;
    assign cache_res_s       = ZERO;
    assign cache_we_unused_s = cache_we_s;
`endif

    assign busy   = (state_r != ST_IDLE);
    assign done   = (state_r == ST_DONE);
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: fixed vector table, corner-case sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 1;
`ifdef MULDIV_RESULT_CACHE_EN
    localparam int HIT_LAT  = 1;
`else
    localparam int HIT_LAT  = FULL_LAT;
`endif

    logic            clk = 1'b0;
    logic            rst, start, flush;
    logic [2:0]      op;
    logic [XLEN-1:0] operand1, operand2;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

`ifdef MULDIV_RESULT_CACHE_EN
    bit          cv = 1'b0;
    logic [31:0] ca, cb;
    logic        cs;
`endif

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (is_special(o, a, b)) return 1;
`ifdef MULDIV_RESULT_CACHE_EN
        if (o[2] && cv && ca == a && cb == b && cs == ~o[0]) return 1;
`endif
        return FULL_LAT;
    endfunction

    task automatic model_note(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_RESULT_CACHE_EN
        if (o[2] && !is_special(o, a, b)) begin
            cv = 1'b1; ca = a; cb = b; cs = ~o[0];
        end
`endif
    endtask

    task automatic model_reset();
`ifdef MULDIV_RESULT_CACHE_EN
        cv = 1'b0;
`endif
    endtask

    function automatic logic [31:0] pick();
        int sel = $urandom_range(0, 5);
        case (sel)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Start an op in cycle 0, scramble inputs while busy, optionally re-pulse start
    // in cycle `poke`; report result, done cycle and busy/done protocol violations.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [31:0] res, output int lat, output int bad);
        lat = 0; bad = 0; res = 32'h0;
        @(negedge clk);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
            if (done === 1'b1) begin lat = c; res = result; end
            start = (c == poke);
            op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
            if (lat != 0) break;
        end
        @(negedge clk);
        if (busy !== 1'b0) bad++;
        if (done !== 1'b0) bad++;
        start = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          poke;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs[14];
        logic [31:0] res, last_res, a, b;
        logic [2:0]  o;
        int          lat, bad, busy_at, saw_done;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 0,  32'hFFFF_FFEB, FULL_LAT};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 0,  32'h4000_0000, FULL_LAT};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0,  32'hFFFF_FFFE, FULL_LAT};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         0,  32'hFFFF_FFFF, FULL_LAT};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5,  32'hFFFF_FFFD, FULL_LAT};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         20, 32'hFFFF_FFFF, HIT_LAT};
        vecs[6]  = '{3'd5, 32'd5,          32'd0,         1,  32'hFFFF_FFFF, 1};
        vecs[7]  = '{3'd7, 32'd5,          32'd0,         0,  32'd5,         1};
        vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0,  32'h8000_0000, 1};
        vecs[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0,  32'h0,         1};
        vecs[10] = '{3'd4, 32'd100,        32'd7,         0,  32'd14,        FULL_LAT};
        vecs[11] = '{3'd6, 32'd100,        32'd7,         0,  32'd2,         HIT_LAT};
        vecs[12] = '{3'd5, 32'd100,        32'd7,         0,  32'd14,        FULL_LAT};
        vecs[13] = '{3'd7, 32'd100,        32'd7,         0,  32'd2,         HIT_LAT};

        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; operand1 = 32'h0; operand2 = 32'h0;
        model_reset();
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_result", 64'(result), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke, res, lat, bad);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_protocol", i), 64'(bad), 64'h0);
            model_note(vecs[i].op, vecs[i].a, vecs[i].b);
        end
        last_res = vecs[13].exp;

        // Flush in cycle 10 of DIV 100/7
        @(negedge clk);
        start = 1'b1; op = 3'd4; operand1 = 32'd100; operand2 = 32'd7;
        busy_at = -1; saw_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 11) busy_at = int'(busy);
            if (done === 1'b1) saw_done++;
            start = 1'b0;
            flush = (c == 10);
        end
        check("flush_busy_c11", 64'(busy_at), 64'h0);
        check("flush_no_done", 64'(saw_done), 64'h0);
        check("flush_result_held", 64'(result), 64'(last_res));

        // Flush coincident with start in IDLE drops the start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; operand1 = 32'd3; operand2 = 32'd5;
        busy_at = -1; saw_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) busy_at = int'(busy);
            if (done === 1'b1) saw_done++;
            start = 1'b0; flush = 1'b0;
        end
        check("flush_start_busy", 64'(busy_at), 64'h0);
        check("flush_start_no_done", 64'(saw_done), 64'h0);
        check("flush_start_result", 64'(result), 64'(last_res));

        // Flush in the DONE cycle of a special case: done still shows
        @(negedge clk);
        start = 1'b1; op = 3'd5; operand1 = 32'd5; operand2 = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        check("flush_done_pulse", 64'(done), 64'h1);
        check("flush_done_result", 64'(result), 64'hFFFF_FFFF);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_idle", 64'(busy), 64'h0);

        // Randomized operations against the model
        a = 32'd1; b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom);
            if ($urandom_range(0, 2) != 0) begin a = pick(); b = pick(); end
            run_op(o, a, b, $urandom_range(0, 40), res, lat, bad);
            check($sformatf("rand%0d_op%0d_result", i, o), 64'(res), 64'(model(o, a, b)));
            check($sformatf("rand%0d_op%0d_latency", i, o), 64'(lat), 64'(model_lat(o, a, b)));
            check($sformatf("rand%0d_protocol", i), 64'(bad), 64'h0);
            model_note(o, a, b);
        end

        // Async reset in the middle of a multiply
        run_op(3'd0, 32'd7, 32'd3, 0, res, lat, bad);
        check("pre_reset_mul", 64'(res), 64'd21);
        @(negedge clk);
        start = 1'b1; op = 3'd0; operand1 = 32'd9; operand2 = 32'd9;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'h0);
        check("async_rst_done", 64'(done), 64'h0);
        check("async_rst_result", 64'(result), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Reset also clears any cached division
        run_op(3'd4, 32'd100, 32'd7, 0, res, lat, bad);
        check("post_reset_div", 64'(res), 64'd14);
        check("post_reset_latency", 64'(lat), 64'(FULL_LAT));
        run_op(3'd6, 32'd100, 32'd7, 0, res, lat, bad);
        check("post_reset_rem", 64'(res), 64'd2);
        check("post_reset_rem_latency", 64'(lat), 64'(HIT_LAT));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
